// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: a single full-adder cell walks WIDTH-bit operands
// LSB first, with valid/ready handshakes on operand entry and result exit.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START_VALID,
    output logic             START_READY,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    input  logic             CI_IN,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CO,
    output logic             OVF,
    output logic             BUSY
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // DONE with RES_READY counts as ready so a new operation can start with no bubble.
    assign START_READY = (state == IDLE) | ((state == DONE) & RES_READY);
    assign accept      = START_VALID & START_READY;
    assign last_bit    = (bit_cnt == LAST_BIT);
    assign RES_VALID   = (state == DONE);
    assign BUSY        = (state == RUN);

    // Written as shifts rather than a concatenation so WIDTH=1 stays legal.
    assign sum_next = (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            bit_cnt <= '0;
            carry   <= 1'b0;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            SUM     <= '0;
            CO      <= 1'b0;
            OVF     <= 1'b0;
        end else if (accept) begin
            state   <= RUN;
            a_sr    <= A_IN;
            b_sr    <= B_IN;
            carry   <= CI_IN;
            bit_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_sr  <= sum_next;
                    carry   <= fa_co;
                    bit_cnt <= bit_cnt + CW'(1);
                    // The carry flop still holds the carry into the MSB on this edge.
                    if (last_bit) begin
                        SUM   <= sum_next;
                        CO    <= fa_co;
                        OVF   <= carry ^ fa_co;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (RES_READY) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed scenarios plus randomized
// operations compared against plain-arithmetic sums, for WIDTH=8 and WIDTH=1.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    int checks = 0;
    int errors = 0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid, start_ready, ci_in, res_valid, res_ready, co, ovf, busy;
    logic [W-1:0] a_in, b_in, sum;

    logic start_valid1, start_ready1, a1, b1, ci1, res_valid1, res_ready1, sum1, co1, ovf1, busy1;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .CLK(clk), .RST_N(rst_n), .START_VALID(start_valid), .START_READY(start_ready),
        .A_IN(a_in), .B_IN(b_in), .CI_IN(ci_in), .RES_VALID(res_valid),
        .RES_READY(res_ready), .SUM(sum), .CO(co), .OVF(ovf), .BUSY(busy)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START_VALID(start_valid1), .START_READY(start_ready1),
        .A_IN(a1), .B_IN(b1), .CI_IN(ci1), .RES_VALID(res_valid1),
        .RES_READY(res_ready1), .SUM(sum1), .CO(co1), .OVF(ovf1), .BUSY(busy1)
    );

    // Reference result {ovf, co, sum}: signed overflow means equal operand signs but a different result sign.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0] full;
        logic       ov;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int n;
        n = 0;
        start_valid = 1'b1;
        a_in = a;
        b_in = b;
        ci_in = ci;
        while (!start_ready && n < 100) begin
            tick();
            n++;
        end
        if (!start_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL start_timeout got start_ready=%0b required 1", start_ready);
        end else begin
            tick();
        end
        start_valid = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        ci_in = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_res(output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        while (!res_valid && cyc < 200) begin
            if (busy) busy_cyc++;
            tick();
            cyc++;
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout got res_valid=%0b required 1", res_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_valid = 1'b0;
        res_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        ci_in = 1'b0;
        start_valid1 = 1'b0;
        res_ready1 = 1'b1;
        a1 = 1'b0;
        b1 = 1'b0;
        ci1 = 1'b0;
        #3;
        checks++;
        if ({busy, res_valid, start_ready, ovf, co, sum} !== {3'b001, 2'b00, {W{1'b0}}}) begin
            errors++;
            $display("[TB] FAIL reset_state got busy=%0b rv=%0b sr=%0b ovf=%0b co=%0b sum=%h required 0 0 1 0 0 00",
                     busy, res_valid, start_ready, ovf, co, sum);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int cyc, bcyc;
        res_ready = 1'b1;
        start_op(8'h35, 8'h4A, 1'b0);
        wait_res(cyc, bcyc);
        checks++;
        if (cyc != W || bcyc != W) begin
            errors++;
            $display("[TB] FAIL basic_latency got cycles=%0d busy=%0d required %0d", cyc, bcyc, W);
        end
        checks++;
        if ({ovf, co, sum} !== {2'b00, 8'h7F}) begin
            errors++;
            $display("[TB] FAIL basic_sum got %h required %h", {ovf, co, sum}, {2'b00, 8'h7F});
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_single_valid got rv=%0b busy=%0b required 0 0", res_valid, busy);
        end
    endtask

    task automatic test_carry;
        int cyc, bcyc;
        res_ready = 1'b1;
        start_op(8'hFF, 8'h01, 1'b0);
        wait_res(cyc, bcyc);
        checks++;
        if ({ovf, co, sum} !== {2'b01, 8'h00}) begin
            errors++;
            $display("[TB] FAIL carry_out got %h required %h", {ovf, co, sum}, {2'b01, 8'h00});
        end
        tick();
        start_op(8'h7F, 8'h00, 1'b1);
        wait_res(cyc, bcyc);
        checks++;
        if ({ovf, co, sum} !== {2'b10, 8'h80}) begin
            errors++;
            $display("[TB] FAIL signed_overflow got %h required %h", {ovf, co, sum}, {2'b10, 8'h80});
        end
        tick();
    endtask

    task automatic test_backpressure;
        int cyc, bcyc;
        logic [W+1:0] exp1, exp2;
        exp1 = model(8'hC3, 8'h5E, 1'b1);
        exp2 = model(8'h12, 8'h9B, 1'b0);
        res_ready = 1'b0;
        start_op(8'hC3, 8'h5E, 1'b1);
        wait_res(cyc, bcyc);
        start_valid = 1'b1;
        a_in = 8'h12;
        b_in = 8'h9B;
        ci_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({start_ready, res_valid, ovf, co, sum} !== {2'b01, exp1}) begin
                errors++;
                $display("[TB] FAIL backpressure_hold got sr=%0b rv=%0b res=%h required 0 1 %h",
                         start_ready, res_valid, {ovf, co, sum}, exp1);
            end
            tick();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL backpressure_release got sr=%0b required 1", start_ready);
        end
        tick();
        start_valid = 1'b0;
        res_ready = 1'b0;
        wait_res(cyc, bcyc);
        checks++;
        if (cyc != W || {ovf, co, sum} !== exp2) begin
            errors++;
            $display("[TB] FAIL backpressure_next got cycles=%0d res=%h required %0d %h", cyc, {ovf, co, sum}, W, exp2);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_run_ignore;
        int cyc, bcyc;
        logic [W+1:0] exp;
        exp = model(8'hA7, 8'h3C, 1'b0);
        res_ready = 1'b0;
        start_op(8'hA7, 8'h3C, 1'b0);
        tick();
        tick();
        start_valid = 1'b1;
        a_in = 8'hFF;
        b_in = 8'hFF;
        ci_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (start_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL run_not_ready got sr=%0b busy=%0b required 0 1", start_ready, busy);
            end
            tick();
        end
        start_valid = 1'b0;
        wait_res(cyc, bcyc);
        checks++;
        if (cyc != W - 4 || {ovf, co, sum} !== exp) begin
            errors++;
            $display("[TB] FAIL run_ignore got cycles=%0d res=%h required %0d %h", cyc, {ovf, co, sum}, W - 4, exp);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int cyc, bcyc;
        logic [W-1:0] qa[4];
        logic [W-1:0] qb[4];
        logic         qc[4];
        for (int i = 0; i < 4; i++) begin
            qa[i] = W'($urandom);
            qb[i] = W'($urandom);
            qc[i] = 1'($urandom_range(0, 1));
        end
        res_ready = 1'b1;
        start_op(qa[0], qb[0], qc[0]);
        for (int i = 0; i < 4; i++) begin
            wait_res(cyc, bcyc);
            checks++;
            if (cyc != W || {ovf, co, sum} !== model(qa[i], qb[i], qc[i])) begin
                errors++;
                $display("[TB] FAIL back_to_back_%0d got cycles=%0d res=%h required %0d %h",
                         i, cyc, {ovf, co, sum}, W, model(qa[i], qb[i], qc[i]));
            end
            if (i < 3) start_op(qa[i+1], qb[i+1], qc[i+1]);
        end
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_random;
        int cyc, bcyc, stall, bad;
        logic [W-1:0] a, b;
        logic         c;
        logic [W+1:0] exp;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 3))
                0: a = '1;
                1: a = '0;
                default: a = W'($urandom);
            endcase
            b = W'($urandom);
            c = 1'($urandom_range(0, 1));
            exp = model(a, b, c);
            stall = $urandom_range(0, 2);
            for (int g = 0; g < stall; g++) tick();
            res_ready = 1'($urandom_range(0, 1));
            start_op(a, b, c);
            wait_res(cyc, bcyc);
            checks++;
            if (cyc != W || {ovf, co, sum} !== exp) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("[TB] FAIL random_%0d got cycles=%0d res=%h required %0d %h", n, cyc, {ovf, co, sum}, W, exp);
            end
            if (!res_ready) begin
                stall = $urandom_range(0, 3);
                for (int g = 0; g < stall; g++) tick();
                res_ready = 1'b1;
            end
            tick();
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc, bcyc;
        res_ready = 1'b0;
        start_op(8'h5A, 8'h33, 1'b1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, res_valid, ovf, co, sum} !== {4'b0000, {W{1'b0}}}) begin
            errors++;
            $display("[TB] FAIL reset_mid_run got busy=%0b rv=%0b res=%h required 0 0 000",
                     busy, res_valid, {ovf, co, sum});
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_discard got rv=%0b busy=%0b required 0 0", res_valid, busy);
        end
        start_op(8'h01, 8'h01, 1'b1);
        wait_res(cyc, bcyc);
        checks++;
        if (cyc != W || {ovf, co, sum} !== {2'b00, 8'h03}) begin
            errors++;
            $display("[TB] FAIL after_reset got cycles=%0d res=%h required %0d %h", cyc, {ovf, co, sum}, W, {2'b00, 8'h03});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_width1;
        int full;
        logic [2:0] exp;
        res_ready1 = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            a1 = i[2];
            b1 = i[1];
            ci1 = i[0];
            full = int'(a1) + int'(b1) + int'(ci1);
            exp[0] = full[0];
            exp[1] = full[1];
            exp[2] = (a1 == b1) && (exp[0] != a1);
            start_valid1 = 1'b1;
            checks++;
            if (start_ready1 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL w1_ready_%0d got %0b required 1", i, start_ready1);
            end
            tick();
            start_valid1 = 1'b0;
            checks++;
            if (busy1 !== 1'b1 || res_valid1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL w1_run_%0d got busy=%0b rv=%0b required 1 0", i, busy1, res_valid1);
            end
            tick();
            checks++;
            if ({res_valid1, ovf1, co1, sum1} !== {1'b1, exp}) begin
                errors++;
                $display("[TB] FAIL w1_result_%0d got rv=%0b res=%b required 1 %b", i, res_valid1, {ovf1, co1, sum1}, exp);
            end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout got no finish required finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_run_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
